// File: rtl/fdiv_arb_pkg.sv
// Shared FPU definitions for the fdiv arbiter slice.
// Provides the single-precision float layout, the default divider latency
// and the quiet-NaN encoding produced by invalid divisions.
package fdiv_arb_pkg;

  localparam int FP_W     = 32;
  localparam int FDIV_LAT = 6;

  localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

// File: rtl/fdiv_arb_fdiv.sv
// Pipelined single-precision divider, y = x1 / x2, LAT cycles from operand
// presentation to a valid y. Round-to-nearest-even; subnormal inputs and
// results flush to signed zero; invalid operations give a quiet NaN.
// Ports:
//   clk_i  : clock
//   rst_ni : synchronous active-low reset of the result pipeline
//   x1_i   : dividend
//   x2_i   : divisor
//   y_o    : quotient, LAT cycles after x1_i/x2_i
module fdiv_arb_fdiv
  import fdiv_arb_pkg::*;
#(
  parameter int LAT = FDIV_LAT
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [FP_W-1:0] x1_i,
  input  logic [FP_W-1:0] x2_i,
  output logic [FP_W-1:0] y_o
);

  fp32_t              a_s;
  fp32_t              b_s;
  logic [23:0]        ma_s;
  logic [23:0]        mb_s;
  logic [49:0]        num_s;
  logic [49:0]        den_s;
  logic [26:0]        quo_s;
  logic [23:0]        rem_s;
  logic [24:0]        mant_s;
  logic               guard_s;
  logic               sticky_s;
  logic signed [9:0]  exp_s;
  logic               sign_s;
  logic               a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic [FP_W-1:0]    q_s;
  logic [FP_W-1:0]    pipe_q [LAT];

  assign a_s = fp32_t'(x1_i);
  assign b_s = fp32_t'(x2_i);

  // Combinational mantissa divide, normalise, round and special-case select.
  always_comb begin
    a_nan_s  = (a_s.exp == 8'hFF) && (a_s.frac != 23'd0);
    b_nan_s  = (b_s.exp == 8'hFF) && (b_s.frac != 23'd0);
    a_inf_s  = (a_s.exp == 8'hFF) && (a_s.frac == 23'd0);
    b_inf_s  = (b_s.exp == 8'hFF) && (b_s.frac == 23'd0);
    a_zero_s = (a_s.exp == 8'h00);
    b_zero_s = (b_s.exp == 8'h00);
    sign_s   = a_s.sign ^ b_s.sign;
    ma_s     = {1'b1, a_s.frac};
    mb_s     = {1'b1, b_s.frac};
    // 26 extra fraction bits leave 24 result bits plus guard plus sticky
    // whichever way the ratio (0.5..2) normalises.
    num_s    = {ma_s, 26'd0};
    den_s    = {26'd0, mb_s};
    quo_s    = 27'(num_s / den_s);
    rem_s    = 24'(num_s % den_s);
    exp_s    = $signed({2'b00, a_s.exp}) - $signed({2'b00, b_s.exp}) + 10'sd127;
    if (quo_s[26]) begin
      mant_s   = {1'b0, quo_s[26:3]};
      guard_s  = quo_s[2];
      sticky_s = (|quo_s[1:0]) | (|rem_s);
    end else begin
      mant_s   = {1'b0, quo_s[25:2]};
      guard_s  = quo_s[1];
      sticky_s = quo_s[0] | (|rem_s);
      exp_s    = exp_s - 10'sd1;
    end
    if (guard_s && (sticky_s || mant_s[0])) begin
      mant_s = mant_s + 25'd1;
    end else begin
      mant_s = mant_s;
    end
    // Rounding carried out past the hidden bit: renormalise.
    if (mant_s[24]) begin
      mant_s = mant_s >> 1;
      exp_s  = exp_s + 10'sd1;
    end else begin
      exp_s  = exp_s;
    end

    if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
      q_s = FP_QNAN;
    end else if (a_inf_s || b_zero_s) begin
      q_s = {sign_s, 8'hFF, 23'd0};
    end else if (a_zero_s || b_inf_s) begin
      q_s = {sign_s, 31'd0};
    end else if (exp_s >= 10'sd255) begin
      q_s = {sign_s, 8'hFF, 23'd0};
    end else if (exp_s <= 10'sd0) begin
      q_s = {sign_s, 31'd0};
    end else begin
      // The hidden bit (mant_s[23]=1) adds the missing 1 back into the
      // exponent field, so exp-1 plus the 24-bit mantissa packs exactly.
      q_s = {sign_s, {exp_s[7:0] - 8'd1, 23'd0} + {7'd0, mant_s[23:0]}};
    end
  end

  // Result delay line giving the fixed LAT-cycle latency.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= q_s;
      for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign y_o = pipe_q[LAT-1];

endmodule

// File: rtl/fdiv_arb.sv
// Round-robin arbiter sharing one pipelined divider among NREQ requesters.
// A LAT-deep tag shift register tracks in-flight operations alongside the
// divider; results land in a DEPTH-entry FIFO. Issue is credit-gated so
// FIFO entries plus in-flight operations never exceed DEPTH.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (one-hot ready)
//   req_x1/req_x2       : packed 32-bit dividends/divisors per requester
//   req_tag             : packed TAGW-bit opaque tags per requester
//   rsp_valid/rsp_ready : result handshake from the FIFO head
//   rsp_y/rsp_id/rsp_tag: quotient, requester index, tag (zero when empty)
//   busy                : operation in flight or FIFO non-empty
module fdiv_arb
  import fdiv_arb_pkg::*;
#(
  parameter  int NREQ  = 2,
  parameter  int LAT   = FDIV_LAT,
  parameter  int DEPTH = 8,
  parameter  int TAGW  = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_x1,
  input  logic [NREQ*32-1:0]   req_x2,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_y,
  output logic [IDW-1:0]       rsp_id,
  output logic [TAGW-1:0]      rsp_tag,
  output logic                 busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]   infl_cnt_q, infl_cnt_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [LAT-1:0]  sr_vld_q;
  logic [IDW-1:0]  sr_id_q  [LAT];
  logic [TAGW-1:0] sr_tag_q [LAT];
  logic [31:0]     mem_y_q   [DEPTH];
  logic [IDW-1:0]  mem_id_q  [DEPTH];
  logic [TAGW-1:0] mem_tag_q [DEPTH];

  logic            found_s;
  logic [IDW-1:0]  gidx_s;
  int unsigned     idx_v;
  logic [CW:0]     used_s;
  logic            credit_ok_s;
  logic            fire_s;
  logic            retire_s;
  logic            pop_s;
  logic            fifo_ne_s;
  logic [31:0]     op_x1_s, op_x2_s;
  logic [TAGW-1:0] op_tag_s;
  logic [31:0]     div_y_s;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    found_s = 1'b0;
    gidx_s  = '0;
    idx_v   = 0;
    for (int off = 1; off <= NREQ; off++) begin
      idx_v = (int'(last_grant_q) + off) % NREQ;
      if (!found_s && req_valid[idx_v]) begin
        found_s = 1'b1;
        gidx_s  = IDW'(idx_v);
      end
    end
  end

  // Credit uses pre-update counts: issue only if one more slot is free.
  assign used_s      = (CW+1)'(fifo_cnt_q) + (CW+1)'(infl_cnt_q);
  assign credit_ok_s = (used_s < (CW+1)'(DEPTH));
  assign fire_s      = !rst && found_s && credit_ok_s;

  // One-hot ready for the winner only.
  always_comb begin
    req_ready = '0;
    if (fire_s) begin
      req_ready[gidx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign op_x1_s  = req_x1[int'(gidx_s)*32 +: 32];
  assign op_x2_s  = req_x2[int'(gidx_s)*32 +: 32];
  assign op_tag_s = req_tag[int'(gidx_s)*TAGW +: TAGW];

  fdiv_arb_fdiv #(
    .LAT (LAT)
  ) u_fdiv (
    .clk_i  (clk),
    .rst_ni (~rst),
    .x1_i   (op_x1_s),
    .x2_i   (op_x2_s),
    .y_o    (div_y_s)
  );

  assign retire_s  = sr_vld_q[LAT-1];
  assign fifo_ne_s = (fifo_cnt_q != '0);
  assign rsp_valid = !rst && fifo_ne_s;
  assign pop_s     = rsp_valid && rsp_ready;

  // Next-state for arbiter pointer, counters and FIFO pointers.
  always_comb begin
    last_grant_d = fire_s ? gidx_s : last_grant_q;
    infl_cnt_d   = infl_cnt_q + CW'(fire_s) - CW'(retire_s);
    fifo_cnt_d   = fifo_cnt_q + CW'(retire_s) - CW'(pop_s);
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    if (retire_s) begin
      wptr_d = (wptr_q == PW'(DEPTH-1)) ? '0 : wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = (rptr_q == PW'(DEPTH-1)) ? '0 : rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
  end

  // Control state; reset drops in-flight ops and empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= IDW'(NREQ-1);
      infl_cnt_q   <= '0;
      fifo_cnt_q   <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      sr_vld_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      infl_cnt_q   <= infl_cnt_d;
      fifo_cnt_q   <= fifo_cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      sr_vld_q[0]  <= fire_s;
      for (int i = 1; i < LAT; i++) sr_vld_q[i] <= sr_vld_q[i-1];
    end
  end

  // Id/tag payload travelling alongside the divider pipeline.
  always_ff @(posedge clk) begin
    sr_id_q[0]  <= gidx_s;
    sr_tag_q[0] <= op_tag_s;
    for (int i = 1; i < LAT; i++) begin
      sr_id_q[i]  <= sr_id_q[i-1];
      sr_tag_q[i] <= sr_tag_q[i-1];
    end
  end

  // FIFO storage write when a tracked operation leaves the divider.
  always_ff @(posedge clk) begin
    if (retire_s && !rst) begin
      mem_y_q[wptr_q]   <= div_y_s;
      mem_id_q[wptr_q]  <= sr_id_q[LAT-1];
      mem_tag_q[wptr_q] <= sr_tag_q[LAT-1];
    end
  end

  assign rsp_y   = fifo_ne_s ? mem_y_q[rptr_q]   : '0;
  assign rsp_id  = fifo_ne_s ? mem_id_q[rptr_q]  : '0;
  assign rsp_tag = fifo_ne_s ? mem_tag_q[rptr_q] : '0;
  assign busy    = !rst && (fifo_ne_s || (infl_cnt_q != '0));

endmodule

// File: tb/tb_fdiv_arb.sv
module tb_fdiv_arb;
  import fdiv_arb_pkg::*;

  localparam int NREQ = 2, LAT = 6, DEPTH = 8, TAGW = 4;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*32-1:0]   req_x1;
  logic [NREQ*32-1:0]   req_x2;
  logic [NREQ*TAGW-1:0] req_tag;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_y;
  logic [0:0]           rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic                 busy;

  fdiv_arb #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_id(rsp_id), .rsp_tag(rsp_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]     y;
    logic [0:0]      id;
    logic [TAGW-1:0] tag;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  int          xfers = 0;
  int          pops  = 0;
  exp_t        sb[$];
  int          grants[$];
  logic [31:0] vx1 [8];
  logic [31:0] vx2 [8];
  logic [31:0] vy  [8];
  logic [31:0] exp_y [NREQ];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Passive monitor: scoreboard transfers, check every pop in order.
  always @(negedge clk) begin
    exp_t e;
    if (dut.fifo_cnt_q > 4'(DEPTH)) chk("fifo_bound", 64'(dut.fifo_cnt_q), 64'(DEPTH));
    if ($countones(req_ready) > 1) chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
    if (rsp_valid && sb.size() == 0) chk("stale_rsp", 64'(rsp_valid), 64'd0);
    if (rsp_valid && rsp_ready && sb.size() != 0) begin
      e = sb.pop_front();
      chk("rsp_order", 64'({rsp_y, rsp_id, rsp_tag}), 64'(e));
      pops++;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        sb.push_back('{y: exp_y[i], id: 1'(i), tag: req_tag[i*TAGW +: TAGW]});
        grants.push_back(i);
        xfers++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int v, input logic [TAGW-1:0] tag);
    req_x1[i*32 +: 32]     = vx1[v];
    req_x2[i*32 +: 32]     = vx2[v];
    req_tag[i*TAGW +: TAGW] = tag;
    exp_y[i]               = vy[v];
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    sb.delete();
    grants.delete();
    step();
    step();
    rst   = 1'b0;
    xfers = 0;
    pops  = 0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while ((sb.size() != 0 || busy) && n < 60) begin
      step();
      n++;
    end
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_sb"}, 64'(sb.size()), 64'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] head;
    vx1[0] = 32'h40C0_0000; vx2[0] = 32'h4000_0000; vy[0] = 32'h4040_0000; // 6/2
    vx1[1] = 32'h3F80_0000; vx2[1] = 32'h4080_0000; vy[1] = 32'h3E80_0000; // 1/4
    vx1[2] = 32'h3F80_0000; vx2[2] = 32'h4000_0000; vy[2] = 32'h3F00_0000; // 1/2
    vx1[3] = 32'h4110_0000; vx2[3] = 32'h4040_0000; vy[3] = 32'h4040_0000; // 9/3
    vx1[4] = 32'h4100_0000; vx2[4] = 32'h4000_0000; vy[4] = 32'h4080_0000; // 8/2
    vx1[5] = 32'hC0C0_0000; vx2[5] = 32'h4000_0000; vy[5] = 32'hC040_0000; // -6/2
    vx1[6] = 32'h3F80_0000; vx2[6] = 32'h4040_0000; vy[6] = 32'h3EAA_AAAB; // 1/3
    vx1[7] = 32'h3F80_0000; vx2[7] = 32'h0000_0000; vy[7] = 32'h7F80_0000; // 1/0
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    req_x1 = '0; req_x2 = '0; req_tag = '0;
    exp_y[0] = '0; exp_y[1] = '0;

    // Reset state: outputs forced low while rst is high.
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rvalid", 64'(rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    do_reset();
    @(negedge clk);
    chk("idle_rvalid", 64'(rsp_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_y", 64'(rsp_y), 64'd0);

    // Single issue: 6.0/2.0, tag 3, visible 7 cycles after transfer.
    step();
    set_req(0, 0, 4'd3);
    req_valid = 2'b01;
    @(negedge clk);
    chk("t1_ready", 64'(req_ready), 64'd1);
    step();
    req_valid = '0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    chk("t1_lat", 64'(n), 64'd7);
    chk("t1_y", 64'(rsp_y), 64'h4040_0000);
    chk("t1_id", 64'(rsp_id), 64'd0);
    chk("t1_tag", 64'(rsp_tag), 64'd3);
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("t1_busy_after", 64'(busy), 64'd0);
    chk("t1_pops", 64'(pops), 64'd1);

    // Contention: both valid for 8 cycles, grants alternate from requester 0.
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      set_req(0, k, 4'(k));
      set_req(1, k, 4'(k + 8));
      step();
    end
    req_valid = '0;
    drain("t2_drain");
    chk("t2_ngrant", 64'(grants.size()), 64'd8);
    for (int k = 0; k < 8 && k < grants.size(); k++) chk("t2_grant", 64'(grants[k]), 64'(k % 2));
    chk("t2_pops", 64'(pops), 64'd8);

    // Backpressure: exactly DEPTH transfers, then ready drops, head stable.
    do_reset();
    set_req(0, 1, 4'd5);
    req_valid = 2'b01;
    for (int k = 0; k < 30; k++) step();
    chk("t3_xfers", 64'(xfers), 64'(DEPTH));
    @(negedge clk);
    chk("t3_ready", 64'(req_ready), 64'd0);
    chk("t3_fifo_full", 64'(dut.fifo_cnt_q), 64'(DEPTH));
    chk("t3_head", 64'(rsp_y), 64'h3E80_0000);
    head = rsp_y;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("t3_stable", 64'({rsp_valid, rsp_y}), 64'({1'b1, head}));
    end

    // Draining: first pop frees one credit, issue resumes next cycle.
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_nocredit", 64'(req_ready), 64'd0);
    step();
    @(negedge clk);
    chk("t4_resume", 64'(req_ready), 64'd1);
    for (int k = 0; k < 4; k++) step();
    req_valid = '0;
    drain("t4_drain");
    chk("t4_xfers", 64'(xfers), 64'd12);
    chk("t4_pops", 64'(pops), 64'd12);

    // Reset with 3 in flight and 2 queued: everything discarded.
    do_reset();
    set_req(0, 2, 4'd1);
    req_valid = 2'b01;
    step();
    set_req(0, 3, 4'd2);
    step();
    req_valid = '0;
    n = 0;
    while (dut.fifo_cnt_q != 4'd2 && n < 20) begin
      step();
      n++;
    end
    req_valid = 2'b01;
    for (int k = 4; k < 7; k++) begin
      set_req(0, k, 4'(k));
      step();
    end
    req_valid = '0;
    @(negedge clk);
    chk("t5_fifo", 64'(dut.fifo_cnt_q), 64'd2);
    chk("t5_infl", 64'(dut.infl_cnt_q), 64'd3);
    step();
    rst = 1'b1;
    req_valid = 2'b11;
    sb.delete();
    @(negedge clk);
    chk("t5_rst_rvalid", 64'(rsp_valid), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_ready", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;
    req_valid = '0;
    pops = 0;
    @(negedge clk);
    chk("t5_rvalid", 64'(rsp_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 15; k++) step();
    chk("t5_nopops", 64'(pops), 64'd0);
    rsp_ready = 1'b0;

    // Simultaneous push and pop with fifo_count = DEPTH-1.
    do_reset();
    req_valid = 2'b01;
    for (int k = 0; k < 8; k++) begin
      set_req(0, k, 4'(k));
      step();
    end
    req_valid = '0;
    chk("t6_xfers", 64'(xfers), 64'd8);
    n = 0;
    while (dut.fifo_cnt_q != 4'd7 && n < 20) begin
      step();
      n++;
    end
    chk("t6_at7", 64'(dut.fifo_cnt_q), 64'd7);
    chk("t6_push", 64'(dut.sr_vld_q[LAT-1]), 64'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t6_still7", 64'(dut.fifo_cnt_q), 64'd7);
    drain("t6_drain");
    chk("t6_pops", 64'(pops), 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
